// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD disparity engine: FSM state encoding,
// accumulator width rule and the unsigned absolute-difference function.
package sad_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CMP   = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  localparam int ABS_W = 32;

  // Wide enough that BLOCK_SIZE^2 maximal differences can never overflow.
  function automatic int sad_width(input int pixel_w, input int block_size);
    return pixel_w + $clog2(block_size * block_size);
  endfunction

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_accum.sv
// Absolute-difference accumulator for one candidate block: clear wins over
// enable, and each enabled cycle adds |l_i - r_i|.
module sad_accum
  import sad_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int SAD_W   = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PIXEL_W-1:0] l_i,
  input  logic [PIXEL_W-1:0] r_i,
  output logic [SAD_W-1:0]   acc_o
);

  logic [SAD_W-1:0]   acc_q, acc_d;
  logic [PIXEL_W-1:0] diff;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    diff  = PIXEL_W'(abs_diff(ABS_W'(l_i), ABS_W'(r_i)));
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + SAD_W'(diff);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sad_disparity_engine.sv
// Block-matching disparity search: fetches L/R blocks per candidate, keeps the
// lowest SAD (ties to lowest d). Optional macro SAD_EARLY_TERM_EN aborts losers early.
module sad_disparity_engine
  import sad_pkg::*;
#(
  parameter int  PIXEL_W        = 8,
  parameter int  BLOCK_SIZE     = 5,
  parameter int  MAX_DISP       = 16,
  parameter int  IMG_WIDTH      = 640,
  parameter int  BUF_ADDR_WIDTH = 19,
  localparam int SAD_W          = sad_width(PIXEL_W, BLOCK_SIZE),
  localparam int DISP_W         = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BUF_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]               start_col,
  output logic [BUF_ADDR_WIDTH-1:0] buf_l_raddr,
  input  logic                      buf_l_rvalid,
  output logic                      buf_l_rready,
  input  logic [PIXEL_W-1:0]        buf_l_rdata,
  output logic [BUF_ADDR_WIDTH-1:0] buf_r_raddr,
  input  logic                      buf_r_rvalid,
  output logic                      buf_r_rready,
  input  logic [PIXEL_W-1:0]        buf_r_rdata,
  output logic                      disp_valid,
  input  logic                      disp_ready,
  output logic [DISP_W-1:0]         disp_out,
  output logic [SAD_W-1:0]          sad_min,
  output logic                      busy
);

  localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [BUF_ADDR_WIDTH-1:0] ROW_STEP = BUF_ADDR_WIDTH'(IMG_WIDTH - BLOCK_SIZE + 1);

  state_e                    state_q, state_d;
  logic [BUF_ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [15:0]               col_q, col_d;
  logic [DISP_W-1:0]         d_q, d_d, best_d_q, best_d_d;
  logic [IDX_W-1:0]          i_q, i_d, j_q, j_d;
  logic                      got_l_q, got_l_d, got_r_q, got_r_d;
  logic [PIXEL_W-1:0]        pix_l_q, pix_l_d, pix_r_q, pix_r_d;
  logic [SAD_W-1:0]          best_q, best_d, acc;
  logic                      have_best_q, have_best_d;

  logic               fire_l, fire_r, elem_done, last_elem, more_cands, cand_win;
  logic               abort, acc_clr;
  logic [16:0]        d_next;
  logic [PIXEL_W-1:0] l_pix, r_pix;

  assign fire_l     = buf_l_rvalid && buf_l_rready;
  assign fire_r     = buf_r_rvalid && buf_r_rready;
  assign elem_done  = (state_q == S_FETCH) && (got_l_q || fire_l) && (got_r_q || fire_r);
  assign last_elem  = (i_q == LAST_IDX) && (j_q == LAST_IDX);
  assign d_next     = 17'(d_q) + 17'd1;
  assign more_cands = (d_next < 17'(MAX_DISP)) && (d_next <= {1'b0, col_q});
  assign cand_win   = !have_best_q || (acc < best_q);
  assign l_pix      = got_l_q ? pix_l_q : buf_l_rdata;
  assign r_pix      = got_r_q ? pix_r_q : buf_r_rdata;

  // Abort only between elements so a half-transferred beat is never dropped.
`ifdef SAD_EARLY_TERM_EN
  assign abort = (state_q == S_FETCH) && have_best_q && (acc >= best_q) && !got_l_q && !got_r_q;
`else
  assign abort = 1'b0;
`endif

  sad_accum #(.PIXEL_W(PIXEL_W), .SAD_W(SAD_W)) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clr_i (acc_clr),
    .en_i  (elem_done),
    .l_i   (l_pix),
    .r_i   (r_pix),
    .acc_o (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (abort || (elem_done && last_elem)) state_d = S_CMP;
      S_CMP:   state_d = more_cands ? S_FETCH : S_OUT;
      S_OUT:   if (disp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buf_l_rready = (state_q == S_FETCH) && !got_l_q && !abort;
    buf_r_rready = (state_q == S_FETCH) && !got_r_q && !abort;
    busy         = (state_q != S_IDLE);
    disp_valid   = (state_q == S_OUT);
    acc_clr      = (state_q == S_IDLE) || (state_q == S_CMP);
  end

  always_comb begin
    base_d      = base_q;
    col_d       = col_q;
    addr_d      = addr_q;
    d_d         = d_q;
    i_d         = i_q;
    j_d         = j_q;
    got_l_d     = got_l_q;
    got_r_d     = got_r_q;
    pix_l_d     = pix_l_q;
    pix_r_d     = pix_r_q;
    best_d      = best_q;
    best_d_d    = best_d_q;
    have_best_d = have_best_q;
    case (state_q)
      S_IDLE: if (start) begin
        base_d      = base_addr;
        col_d       = start_col;
        addr_d      = base_addr;
        d_d         = '0;
        i_d         = '0;
        j_d         = '0;
        got_l_d     = 1'b0;
        got_r_d     = 1'b0;
        have_best_d = 1'b0;
      end
      S_FETCH: begin
        if (fire_l) begin
          got_l_d = 1'b1;
          pix_l_d = buf_l_rdata;
        end
        if (fire_r) begin
          got_r_d = 1'b1;
          pix_r_d = buf_r_rdata;
        end
        if (elem_done) begin
          got_l_d = 1'b0;
          got_r_d = 1'b0;
          if (!last_elem) begin
            if (j_q == LAST_IDX) begin
              j_d    = '0;
              i_d    = i_q + IDX_W'(1);
              addr_d = addr_q + ROW_STEP;
            end else begin
              j_d    = j_q + IDX_W'(1);
              addr_d = addr_q + BUF_ADDR_WIDTH'(1);
            end
          end
        end
      end
      S_CMP: begin
        if (cand_win) begin
          best_d      = acc;
          best_d_d    = d_q;
          have_best_d = 1'b1;
        end
        if (more_cands) begin
          d_d    = d_q + DISP_W'(1);
          addr_d = base_q;
          i_d    = '0;
          j_d    = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      d_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      got_l_q     <= 1'b0;
      got_r_q     <= 1'b0;
      pix_l_q     <= '0;
      pix_r_q     <= '0;
      best_q      <= '0;
      best_d_q    <= '0;
      have_best_q <= 1'b0;
    end else begin
      base_q      <= base_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      d_q         <= d_d;
      i_q         <= i_d;
      j_q         <= j_d;
      got_l_q     <= got_l_d;
      got_r_q     <= got_r_d;
      pix_l_q     <= pix_l_d;
      pix_r_q     <= pix_r_d;
      best_q      <= best_d;
      best_d_q    <= best_d_d;
      have_best_q <= have_best_d;
    end
  end

  assign buf_l_raddr = addr_q;
  assign buf_r_raddr = addr_q - BUF_ADDR_WIDTH'(d_q);
  assign disp_out    = best_d_q;
  assign sad_min     = best_q;

endmodule

// File: doc/sad_disparity_engine.md
SAD_DISPARITY_ENGINE -- requirements
Module: sad_disparity_engine

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8: pixel width, unsigned.
REQ-002 SHALL have parameter BLOCK_SIZE, default 5: block edge length, in pixels.
REQ-003 SHALL have parameter MAX_DISP, default 16: number of candidate disparities, 0..MAX_DISP-1.
REQ-004 SHALL have parameter IMG_WIDTH, default 640: image line stride, in pixels.
REQ-005 SHALL have parameter BUF_ADDR_WIDTH, default 19: width of the buffer address.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports start in 1 (one-cycle request); base_addr in BUF_ADDR_WIDTH (top-left pixel of the left block); start_col in 16 (column of base_addr).
REQ-008 SHALL have ports buf_l_raddr out BUF_ADDR_WIDTH; buf_l_rvalid in 1; buf_l_rready out 1; buf_l_rdata in PIXEL_W. The buf_r_* ports SHALL be identical, for the right image.
REQ-009 SHALL have ports disp_valid out 1; disp_ready in 1; disp_out out clog2(MAX_DISP); sad_min out SAD_W; busy out 1.

Function
REQ-010 SHALL define SAD_W = PIXEL_W + clog2(BLOCK_SIZE*BLOCK_SIZE); the accumulator SHALL never overflow or saturate.
REQ-011 SHALL compute the pixel difference as the unsigned absolute difference |L-R|, PIXEL_W bits wide.
REQ-012 SHALL sample start only in IDLE; start SHALL be ignored in every other state.
REQ-013 SHALL use FSM states IDLE -> FETCH -> CMP -> (FETCH for the next d | OUT) -> IDLE.
REQ-014 In FETCH, for element (i,j), SHALL set buf_l_raddr = base_addr + i*IMG_WIDTH + j and buf_r_raddr = buf_l_raddr - d. Order is row-major.
REQ-015 SHALL hold each rready high, with a stable raddr, until that buffer's beat transfers (rvalid && rready). It SHALL then deassert that rready until the other buffer's beat also transfers.
REQ-016 SHALL accumulate |L-R| for an element only once both beats of that element have transferred. The next element SHALL be issued on the following cycle.
REQ-017 With zero-wait buffers, SHALL process one element per cycle. Each candidate SHALL take BLOCK_SIZE^2 FETCH cycles plus 1 CMP cycle.
REQ-018 SHALL evaluate only candidates d <= start_col. Candidates with d > start_col SHALL be skipped with no buffer reads. d=0 SHALL always be evaluated.
REQ-019 In CMP, SHALL replace best when acc < best (strict), so ties keep the lowest d. The first evaluated candidate SHALL always load best.
REQ-020 In OUT, SHALL assert disp_valid and hold disp_out and sad_min stable until disp_ready. On the handshake it SHALL return to IDLE on the next cycle.
REQ-021 SHALL assert busy in every state except IDLE.
REQ-022 Outside FETCH, SHALL hold buf_l_rready and buf_r_rready low.

Reset
REQ-023 Reset SHALL force IDLE. All outputs SHALL go to 0: raddrs, rreadys, disp_valid, disp_out, sad_min and busy.
REQ-024 Reset SHALL clear the accumulator, the best value and all counters. Reset in any state, including mid-FETCH with a beat half-transferred, SHALL abandon the operation and produce no result.

Configuration
REQ-025 With SAD_EARLY_TERM_EN defined, FETCH SHALL abort a candidate once acc >= best after the first candidate, and go directly to CMP. That candidate SHALL lose.
REQ-026 SAD_EARLY_TERM_EN SHALL NOT change disp_out or sad_min. Only cycle count and read count SHALL differ.
REQ-027 Without SAD_EARLY_TERM_EN, every eligible candidate SHALL be fully accumulated.

Structure
REQ-028 Package sad_pkg SHALL hold the FSM state enum, the SAD_W width function and the abs_diff function.
REQ-029 Sub-module sad_accum SHALL contain abs-diff, the accumulator, clear and enable. The FSM, address generation and the winner register SHALL stay in the top module.

Verification
REQ-030 Setup: PIXEL_W=8, BLOCK_SIZE=3, MAX_DISP=4, IMG_WIDTH=16. Scenario: L=R=50 flat, start_col=10 -> disp_out=0, sad_min=0; total FETCH+CMP cycles 4*10=40 with zero-wait buffers.
REQ-031 Scenario: L[r][c]=10c, R[r][c]=10(c+2), start_col=10 -> disp_out=2, sad_min=0. The SAD for d=0 SHALL be 180.
REQ-032 Scenario: L=255, R=0 flat, start_col=1 -> only d=0,1 read (18 reads per buffer); disp_out=0, sad_min=2295.
REQ-033 Scenario: random rvalid stalls on both buffers, independently (~50%) -> same results as REQ-031. Each raddr SHALL stay stable while its rready is high.
REQ-034 Scenario: disp_ready low 5 cycles in OUT, with start pulsed -> outputs stable; start ignored; IDLE one cycle after the handshake.
REQ-035 Scenario: rst asserted on the 4th FETCH cycle -> next cycle all outputs 0 and state IDLE. A new start then SHALL produce correct results.
